// File: rtl/mcht_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mcht_rx : Manchester line decoder, oversampled, re-aligns on each mid-bit edge
// Revision: 1.0
// ============================================================================
module mcht_rx #(
    parameter int OVS    = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              rx_busy
);

    localparam int C_CNT_MAX = 5 * OVS / 4;
    localparam int C_CNT_MIN = 3 * OVS / 4;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_IDX_W   = $clog2(DATA_W + 1);

    localparam logic [C_CNT_W-1:0] C_CNT_MAX_V  = C_CNT_W'(C_CNT_MAX);
    localparam logic [C_CNT_W-1:0] C_CNT_MIN_V  = C_CNT_W'(C_CNT_MIN);
    localparam logic [C_CNT_W-1:0] C_GAP_LAST_V = C_CNT_W'(OVS - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST_V = C_IDX_W'(DATA_W - 1);

    localparam logic [2:0] C_S_IDLE = 3'd0;
    localparam logic [2:0] C_S_DATA = 3'd1;
    localparam logic [2:0] C_S_DONE = 3'd2;
    localparam logic [2:0] C_S_ERR  = 3'd3;
    localparam logic [2:0] C_S_GAP  = 3'd4;

    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [2:0]          r_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_data;

    logic                w_edge;
    logic [C_CNT_W-1:0]  w_cnt_inc;
    logic                w_mid;
    logic [DATA_W-1:0]   w_shift_nxt;

    assign w_edge      = r_s2 ^ r_s3;
    assign w_cnt_inc   = (r_cnt == C_CNT_MAX_V) ? r_cnt : r_cnt + 1'b1;
    // w_cnt_inc is the number of cycles elapsed since the last accepted mid-bit edge
    assign w_mid       = w_edge && (w_cnt_inc >= C_CNT_MIN_V);
    assign w_shift_nxt = {r_shift[DATA_W-2:0], r_s2};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= rx_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
        end else if (!en) begin
            r_state <= C_S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                C_S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (w_edge && r_s2) begin
                        r_state <= C_S_DATA;
                    end
                end
                C_S_DATA: begin
                    // Silence for the full window wins over a coincident late edge
                    if (r_cnt == C_CNT_MAX_V) begin
                        r_state <= C_S_ERR;
                        r_cnt   <= '0;
                    end else if (w_mid) begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= '0;
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == C_IDX_LAST_V) begin
                            r_data  <= w_shift_nxt;
                            r_state <= C_S_DONE;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                C_S_DONE, C_S_ERR: begin
                    r_state <= C_S_GAP;
                    r_cnt   <= '0;
                end
                C_S_GAP: begin
                    if (r_cnt == C_GAP_LAST_V) begin
                        r_state <= C_S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= C_S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_data  = r_data;
    assign rx_valid = (r_state == C_S_DONE);
    assign rx_err   = (r_state == C_S_ERR);
    assign rx_busy  = (r_state != C_S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mcht_rx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mcht_rx : randomized Manchester frames checked against an interval-rule model
module tb_mcht_rx;

    localparam int OVS  = 8;
    localparam int DW   = 8;
    localparam int MINC = 3 * OVS / 4;
    localparam int MAXC = 5 * OVS / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          rx_in = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_err;
    logic          rx_busy;

    mcht_rx #(.OVS(OVS), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .rx_in(rx_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } ev_t;

    ev_t vq[$];
    int  eq[$];
    int  both_cnt = 0;
    int  busy_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) vq.push_back(ev_t'{c: cyc, d: rx_data});
        if (rx_err) eq.push_back(cyc);
        if (rx_valid && rx_err) both_cnt++;
        if (rx_busy) busy_cnt++;
    end

    int            iv[1:DW];
    int            mids[0:DW];
    bit            wave[$];
    int            bad;
    logic [DW-1:0] last_data;

    function automatic void set_ideal();
        for (int i = 1; i <= DW; i++) iv[i] = OVS;
    endfunction

    // Line waveform from bit values and mid-bit intervals; cut forces the line low
    // from the start of bit 'cut' onward (that bit's mid transition never appears).
    task automatic build(input logic [DW-1:0] data, input int cut);
        int   bnd[0:DW+1];
        logic b[0:DW];
        int   total;
        logic lvl;
        wave.delete();
        bad = -1;
        b[0] = 1'b1;
        for (int i = 1; i <= DW; i++) b[i] = data[DW-i];
        mids[0] = OVS / 2;
        for (int i = 1; i <= DW; i++) mids[i] = mids[i-1] + iv[i];
        for (int i = 1; i <= DW; i++)
            if (bad < 0 && (i == cut || iv[i] < MINC || iv[i] > MAXC)) bad = i;
        bnd[0] = 0;
        for (int i = 1; i <= DW; i++) bnd[i] = (mids[i-1] + mids[i]) / 2;
        bnd[DW+1] = mids[DW] + OVS / 2;
        total = bnd[DW+1] + 2 * OVS;
        for (int c = 0; c < total; c++) begin
            lvl = 1'b0;
            for (int i = 0; i <= DW; i++) begin
                if (c >= bnd[i] && c < mids[i]) lvl = !b[i];
                else if (c >= mids[i] && c < bnd[i+1]) lvl = b[i];
            end
            if (cut >= 1 && cut <= DW && c >= bnd[cut]) lvl = 1'b0;
            wave.push_back(lvl);
        end
    endtask

    task automatic play(input int n, output int base);
        base = cyc;
        for (int j = 0; j < n && wave.size() > 0; j++) begin
            @(posedge clk);
            #1;
            rx_in = wave.pop_front();
            if (j == 0) base = cyc;
        end
    endtask

    task automatic clr();
        vq.delete();
        eq.delete();
    endtask

    task automatic run_frame(input logic [DW-1:0] data, input int cut, output int base);
        build(data, cut);
        play(wave.size(), base);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rx_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        rst = 1'b0;
        last_data = '0;
    endtask

    task automatic test_single();
        int base, exp_c;
        set_ideal();
        clr();
        run_frame(8'hA5, 0, base);
        exp_c = base + mids[DW] + 3;
        checks++; if (vq.size() != 1) begin errors++; $display("FAIL single_nvalid got=%0d exp=1", vq.size()); end
        if (vq.size() >= 1) begin
            checks++; if (vq[0].c != exp_c) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", vq[0].c, exp_c); end
            checks++; if (vq[0].d !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", vq[0].d); end
        end
        checks++; if (eq.size() != 0) begin errors++; $display("FAIL single_nerr got=%0d exp=0", eq.size()); end
        @(negedge clk);
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_hold got=%h exp=a5", rx_data); end
        last_data = 8'hA5;
    endtask

    task automatic test_back_to_back();
        int b0, b1, m0, m1;
        set_ideal();
        clr();
        run_frame(8'h00, 0, b0);
        m0 = mids[DW];
        @(negedge clk);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_gap got=%b exp=0", rx_busy); end
        run_frame(8'hFF, 0, b1);
        m1 = mids[DW];
        checks++; if (vq.size() != 2) begin errors++; $display("FAIL b2b_nvalid got=%0d exp=2", vq.size()); end
        if (vq.size() >= 2) begin
            checks++; if (vq[0].d !== 8'h00 || vq[0].c != b0 + m0 + 3) begin errors++; $display("FAIL b2b_first got=%h@%0d exp=00@%0d", vq[0].d, vq[0].c, b0 + m0 + 3); end
            checks++; if (vq[1].d !== 8'hFF || vq[1].c != b1 + m1 + 3) begin errors++; $display("FAIL b2b_second got=%h@%0d exp=ff@%0d", vq[1].d, vq[1].c, b1 + m1 + 3); end
        end
        checks++; if (eq.size() != 0) begin errors++; $display("FAIL b2b_nerr got=%0d exp=0", eq.size()); end
        last_data = 8'hFF;
    endtask

    task automatic test_jitter();
        int base, exp_c;
        for (int i = 1; i <= DW; i++) iv[i] = (i % 2 == 1) ? MINC : MAXC;
        clr();
        run_frame(8'h3C, 0, base);
        exp_c = base + mids[DW] + 3;
        checks++; if (vq.size() != 1) begin errors++; $display("FAIL jitter_nvalid got=%0d exp=1", vq.size()); end
        if (vq.size() >= 1) begin
            checks++; if (vq[0].d !== 8'h3C || vq[0].c != exp_c) begin errors++; $display("FAIL jitter_data got=%h@%0d exp=3c@%0d", vq[0].d, vq[0].c, exp_c); end
        end
        checks++; if (eq.size() != 0) begin errors++; $display("FAIL jitter_nerr got=%0d exp=0", eq.size()); end
        last_data = 8'h3C;
        iv[5] = MAXC + 1;
        clr();
        run_frame(8'h3C, 6, base);
        exp_c = base + mids[bad-1] + 3 + MAXC + 1;
        checks++; if (eq.size() != 1) begin errors++; $display("FAIL late_nerr got=%0d exp=1", eq.size()); end
        if (eq.size() >= 1) begin
            checks++; if (eq[0] != exp_c) begin errors++; $display("FAIL late_err_time got=%0d exp=%0d", eq[0], exp_c); end
        end
        checks++; if (vq.size() != 0) begin errors++; $display("FAIL late_nvalid got=%0d exp=0", vq.size()); end
        checks++; if (rx_data !== last_data) begin errors++; $display("FAIL late_data_kept got=%h exp=%h", rx_data, last_data); end
    endtask

    task automatic test_missing();
        int base, exp_c;
        set_ideal();
        clr();
        run_frame(8'h96, 3, base);
        exp_c = base + mids[bad-1] + 3 + MAXC + 1;
        checks++; if (eq.size() != 1) begin errors++; $display("FAIL miss_nerr got=%0d exp=1", eq.size()); end
        if (eq.size() >= 1) begin
            checks++; if (eq[0] != exp_c) begin errors++; $display("FAIL miss_err_time got=%0d exp=%0d", eq[0], exp_c); end
        end
        checks++; if (vq.size() != 0) begin errors++; $display("FAIL miss_nvalid got=%0d exp=0", vq.size()); end
        @(negedge clk);
        checks++; if (rx_data !== last_data) begin errors++; $display("FAIL miss_data_kept got=%h exp=%h", rx_data, last_data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL miss_busy got=%b exp=0", rx_busy); end
        clr();
        run_frame(8'h5A, 0, base);
        checks++; if (vq.size() != 1 || (vq.size() > 0 && vq[0].d !== 8'h5A)) begin errors++; $display("FAIL miss_recover got=%0d/%h exp=1/5a", vq.size(), rx_data); end
        last_data = 8'h5A;
    endtask

    task automatic test_rst_midframe();
        int base;
        set_ideal();
        clr();
        build(8'h64, 6);
        play(mids[5] + 2, base);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({rx_data, rx_valid, rx_err, rx_busy} !== '0) begin errors++; $display("FAIL rstmid_outputs got=%h/%b%b%b exp=0/000", rx_data, rx_valid, rx_err, rx_busy); end
        rst = 1'b0;
        play(wave.size(), base);
        checks++; if (vq.size() + eq.size() != 0) begin errors++; $display("FAIL rstmid_strobes got=%0d exp=0", vq.size() + eq.size()); end
        clr();
        run_frame(8'hC3, 0, base);
        checks++; if (vq.size() != 1 || (vq.size() > 0 && (vq[0].d !== 8'hC3 || vq[0].c != base + mids[DW] + 3))) begin errors++; $display("FAIL rstmid_next got=%0d/%h exp=1/c3", vq.size(), rx_data); end
        last_data = 8'hC3;
    endtask

    task automatic test_enable();
        int base;
        set_ideal();
        clr();
        @(negedge clk);
        en = 1'b0;
        busy_cnt = 0;
        run_frame(8'h11, 0, base);
        checks++; if (vq.size() + eq.size() != 0) begin errors++; $display("FAIL en_off_strobes got=%0d exp=0", vq.size() + eq.size()); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL en_off_busy got=%0d exp=0", busy_cnt); end
        checks++; if (rx_data !== last_data) begin errors++; $display("FAIL en_off_data got=%h exp=%h", rx_data, last_data); end
        @(negedge clk);
        en = 1'b1;
        clr();
        run_frame(8'h22, 0, base);
        checks++; if (vq.size() != 1 || (vq.size() > 0 && vq[0].d !== 8'h22)) begin errors++; $display("FAIL en_on_data got=%0d/%h exp=1/22", vq.size(), rx_data); end
        last_data = 8'h22;
    endtask

    task automatic test_random();
        int            base, exp_c, j, cut;
        logic [DW-1:0] d;
        for (int n = 0; n < 10; n++) begin
            d = DW'($urandom);
            for (int i = 1; i <= DW; i++) iv[i] = $urandom_range(MINC, MAXC);
            cut = 0;
            if ($urandom_range(0, 2) == 0) begin
                j = $urandom_range(1, DW);
                iv[j] = MAXC + 1;
                cut = j + 1;
            end
            clr();
            run_frame(d, cut, base);
            if (bad < 0) begin
                exp_c = base + mids[DW] + 3;
                checks++; if (vq.size() != 1 || eq.size() != 0) begin errors++; $display("FAIL rand_ok_counts n=%0d got=%0d/%0d exp=1/0", n, vq.size(), eq.size()); end
                else begin
                    checks++; if (vq[0].d !== d || vq[0].c != exp_c) begin errors++; $display("FAIL rand_ok_data n=%0d got=%h@%0d exp=%h@%0d", n, vq[0].d, vq[0].c, d, exp_c); end
                end
                last_data = d;
            end else begin
                exp_c = base + mids[bad-1] + 3 + MAXC + 1;
                checks++; if (eq.size() != 1 || vq.size() != 0) begin errors++; $display("FAIL rand_err_counts n=%0d got=%0d/%0d exp=1/0", n, eq.size(), vq.size()); end
                else begin
                    checks++; if (eq[0] != exp_c) begin errors++; $display("FAIL rand_err_time n=%0d got=%0d exp=%0d", n, eq[0], exp_c); end
                end
                checks++; if (rx_data !== last_data) begin errors++; $display("FAIL rand_err_data n=%0d got=%h exp=%h", n, rx_data, last_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_jitter();
        test_missing();
        test_rst_midframe();
        test_enable();
        test_random();
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL valid_err_overlap got=%0d exp=0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
